// File: rtl/counter_pkg.sv
// Shared definitions for the mode counter: sequence-select encodings.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_ODD  = 2'b00,
    MODE_EVEN = 2'b01,
    MODE_ALL  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

endpackage

// File: rtl/step_calc.sv
// Combinational next-value and boundary detection for the mode counter.
module step_calc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  mode_e            mode,
  input  logic             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] next_out,
  output logic             at_bound
);

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] stp;
  logic             aligned;
  logic             on_edge;

  always_comb begin
    lo      = '0;
    hi      = '1;
    stp     = WIDTH'(1);
    aligned = 1'b1;
    unique case (mode)
      MODE_ODD: begin
        lo      = WIDTH'(1);
        stp     = WIDTH'(2);
        aligned = cur[0];
      end
      MODE_EVEN: begin
        hi      = {{(WIDTH-1){1'b1}}, 1'b0};
        stp     = WIDTH'(2);
        aligned = ~cur[0];
      end
      MODE_ALL:  ;
      MODE_HOLD: ;
    endcase
  end

  assign on_edge = dir ? (cur == hi) : (cur == lo);

  always_comb begin
    next_out = cur;
    at_bound = 1'b0;
    if (mode != MODE_HOLD) begin
      if (!aligned) begin
        // Parity mismatch: this cycle only moves onto the mode's lattice.
        next_out = dir ? cur + WIDTH'(1) : cur - WIDTH'(1);
      end else if (on_edge) begin
        at_bound = 1'b1;
        next_out = sat ? cur : (dir ? lo : hi);
      end else begin
        next_out = dir ? cur + stp : cur - stp;
      end
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Odd/even/all up-down counter with wrap or saturate policy and terminal-count pulse.
module mode_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  logic [WIDTH-1:0] next_out;
  logic             at_bound;

  step_calc #(
    .WIDTH(WIDTH)
  ) u_step_calc (
    .cur      (out),
    .mode     (mode_e'(mode)),
    .dir      (dir),
    .sat      (sat),
    .next_out (next_out),
    .at_bound (at_bound)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      out <= load_val;
      tc  <= 1'b0;
    end else if (en) begin
      out <= next_out;
      tc  <= at_bound;
    end else begin
      tc  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter: directed sequences plus randomized traffic.
module tb_mode_counter;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    int    out;
    bit    tc;
    string name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         dir = 1'b0;
  logic         sat = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] out;
  logic         tc;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_out = 0;

  mode_counter #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  // Reference: values legal in a mode form the lattice lo, lo+st, ..., hi.
  function automatic void model_step(input int v, input bit e, input bit [1:0] m, input bit d,
                                     input bit s, input bit l, input int lv,
                                     output int nv, output bit ntc);
    int lo, hi, st;
    nv  = v;
    ntc = 1'b0;
    if (l) begin
      nv = lv;
      return;
    end
    if (!e || m == 2'b11) return;
    st = (m == 2'b10) ? 1 : 2;
    lo = (m == 2'b00) ? 1 : 0;
    hi = (m == 2'b01) ? MAXV - 1 : MAXV;
    if (((v - lo) % st) != 0) begin
      nv = (v + (d ? 1 : -1) + MAXV + 1) % (MAXV + 1);
    end else if (d && v == hi) begin
      nv  = s ? v : lo;
      ntc = 1'b1;
    end else if (!d && v == lo) begin
      nv  = s ? v : hi;
      ntc = 1'b1;
    end else begin
      nv = d ? v + st : v - st;
    end
  endfunction

  function automatic void check(input string nm, input int act_o, input bit act_t,
                                input int exp_o, input bit exp_t);
    checks++;
    if (act_o != exp_o || act_t != exp_t) begin
      failures++;
      $display("FAIL %s: got out=%0d tc=%0b, want out=%0d tc=%0b", nm, act_o, act_t, exp_o,
               exp_t);
    end
  endfunction

  // Called at a falling edge; drives one cycle and queues the expected result.
  // eo < 0 means the reference model supplies the expectation.
  task automatic step(input bit e, input bit [1:0] m, input bit d, input bit s, input bit l,
                      input int lv, input int eo, input int et, input string nm);
    exp_t x;
    int   nv;
    bit   ntc;
    en       = e;
    mode     = m;
    dir      = d;
    sat      = s;
    load     = l;
    load_val = W'(lv);
    model_step(model_out, e, m, d, s, l, lv, nv, ntc);
    if (eo >= 0) begin
      nv  = eo;
      ntc = bit'(et);
    end
    x.out  = nv;
    x.tc   = ntc;
    x.name = nm;
    exp_q.push_back(x);
    model_out = nv;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check(x.name, int'(out), tc, x.out, x.tc);
      end
    end
  end

  initial begin : driver
    int lv;
    repeat (2) @(negedge clk);
    check("reset_state", int'(out), tc, 0, 1'b0);
    rst = 1'b1;
    model_out = 0;

    // Odd up from reset: realign 0 -> 1 then step by two.
    step(1, 2'b00, 1, 0, 0, 0, 1, 0, "odd_up_0");
    step(1, 2'b00, 1, 0, 0, 0, 3, 0, "odd_up_1");
    step(1, 2'b00, 1, 0, 0, 0, 5, 0, "odd_up_2");
    step(1, 2'b00, 1, 0, 0, 0, 7, 0, "odd_up_3");

    // Odd up wrap past 255.
    step(0, 2'b00, 1, 0, 1, 253, 253, 0, "wrap_load");
    step(1, 2'b00, 1, 0, 0, 0, 255, 0, "wrap_0");
    step(1, 2'b00, 1, 0, 0, 0, 1, 1, "wrap_1");
    step(1, 2'b00, 1, 0, 0, 0, 3, 0, "wrap_2");

    // Even down saturate at 0 with repeated tc.
    step(0, 2'b01, 0, 1, 1, 4, 4, 0, "sat_load");
    step(1, 2'b01, 0, 1, 0, 0, 2, 0, "sat_0");
    step(1, 2'b01, 0, 1, 0, 0, 0, 0, "sat_1");
    step(1, 2'b01, 0, 1, 0, 0, 0, 1, "sat_2");
    step(1, 2'b01, 0, 1, 0, 0, 0, 1, "sat_3");

    // Realign after load, then mid-count mode change.
    step(0, 2'b00, 1, 0, 1, 100, 100, 0, "realign_load");
    step(1, 2'b00, 1, 0, 0, 0, 101, 0, "realign_0");
    step(1, 2'b00, 1, 0, 0, 0, 103, 0, "realign_1");
    step(1, 2'b10, 1, 0, 0, 0, 104, 0, "all_0");
    step(1, 2'b10, 1, 0, 0, 0, 105, 0, "all_1");

    // Load beats enable; hold mode freezes the count.
    step(1, 2'b10, 1, 0, 1, 9, 9, 0, "load_pri");
    step(1, 2'b11, 1, 0, 0, 0, 9, 0, "hold_0");
    step(1, 2'b11, 0, 1, 0, 0, 9, 0, "hold_1");

    // Asynchronous reset mid-count.
    step(0, 2'b10, 1, 0, 1, 35, 35, 0, "rst_load");
    step(1, 2'b10, 1, 0, 0, 0, 36, 0, "rst_cnt_0");
    step(1, 2'b10, 1, 0, 0, 0, 37, 0, "rst_cnt_1");
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset", int'(out), tc, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_out = 0;
    step(1, 2'b00, 1, 0, 0, 0, 1, 0, "post_reset");

    // Randomized traffic, values biased toward the boundaries.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       lv = $urandom_range(0, 3);
        1:       lv = $urandom_range(MAXV - 3, MAXV);
        default: lv = $urandom_range(0, MAXV);
      endcase
      step(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 15) == 0), lv, -1, 0, "random");
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
